// File: rtl/decode_imm_stage.sv
// Decode/immediate-expansion stage: opcode -> immsrc/imm/illegal, held with instr/pc in a 2-entry skid FIFO.
// Build option SHAMT_IMM_EN: OP-IMM shifts (funct3 001/101) use the zero-extended shamt immediate (immsrc 101).
module decode_imm_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  out_immsrc,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;
  localparam logic [2:0] SRC_SH = 3'b101;

  entry_t      mem_q [2];
  entry_t      dec;
  entry_t      head;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;

  // Opcode decode and immediate expansion, computed before the entry is stored
  always_comb begin
    dec         = '0;
    dec.instr   = in_instr;
    dec.pc      = in_pc;
    dec.immsrc  = SRC_I;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b1100111, 7'b0110011, 7'b1110011: dec.immsrc = SRC_I;
      7'b0010011: begin
`ifdef SHAMT_IMM_EN
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) dec.immsrc = SRC_SH;
        else dec.immsrc = SRC_I;
`else
        dec.immsrc = SRC_I;
`endif
      end
      7'b0100011:             dec.immsrc = SRC_S;
      7'b1100011:             dec.immsrc = SRC_B;
      7'b0110111, 7'b0010111: dec.immsrc = SRC_U;
      7'b1101111:             dec.immsrc = SRC_J;
      default:                dec.illegal = 1'b1;
    endcase

    case (dec.immsrc)
      SRC_I:   dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
      SRC_S:   dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SRC_B:   dec.imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      SRC_U:   dec.imm = {in_instr[31:12], 12'b0};
      SRC_J:   dec.imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      SRC_SH:  dec.imm = {27'b0, in_instr[24:20]};
      default: dec.imm = '0;
    endcase
    if (dec.illegal) dec.imm = '0;
  end

  // Ready comes from occupancy only, so there is no combinational path from out_ready
  assign in_ready = !rst && (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= dec;
  end

  // Outputs come from the head slot and are zeroed whenever nothing is valid
  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (count_q != 2'd0);
  assign out_instr   = out_valid ? head.instr   : 32'b0;
  assign out_pc      = out_valid ? head.pc      : 32'b0;
  assign out_immsrc  = out_valid ? head.immsrc  : 3'b0;
  assign out_imm     = out_valid ? head.imm     : 32'b0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage; expected values are hand-derived constants.
module tb_decode_imm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_immsrc;
  logic [31:0] out_imm;
  logic        out_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_imm_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_immsrc(out_immsrc), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);

    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Streaming decode with out_ready high: one instruction per cycle
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h100);  // addi x1,x0,-1
    tick();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_immsrc", 32'(out_immsrc), 32'd0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_illegal", 32'(out_illegal), 32'd0);
    chk("addi_pc", out_pc, 32'h100);

    drive(1'b1, 32'hFE000EE3, 32'h104);  // beq x0,x0,-4
    tick();
    chk("beq_immsrc", 32'(out_immsrc), 32'd2);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_pc", out_pc, 32'h104);

    drive(1'b1, 32'h000000EF, 32'h108);  // jal x1,0
    tick();
    chk("jal_immsrc", 32'(out_immsrc), 32'd4);
    chk("jal_imm", out_imm, 32'h0);

    drive(1'b1, 32'h40315093, 32'h10C);  // srai x1,x2,3
    tick();
`ifdef SHAMT_IMM_EN
    chk("srai_immsrc", 32'(out_immsrc), 32'd5);
    chk("srai_imm", out_imm, 32'h00000003);
`else
    chk("srai_immsrc", 32'(out_immsrc), 32'd0);
    chk("srai_imm", out_imm, 32'h00000403);
`endif

    drive(1'b1, 32'h00112423, 32'h110);  // sw x1,8(x2)
    tick();
    chk("sw_immsrc", 32'(out_immsrc), 32'd1);
    chk("sw_imm", out_imm, 32'h8);

    drive(1'b1, 32'h123450B7, 32'h114);  // lui x1,0x12345
    tick();
    chk("lui_immsrc", 32'(out_immsrc), 32'd3);
    chk("lui_imm", out_imm, 32'h12345000);

    drive(1'b1, 32'h002081B3, 32'h118);  // add x3,x1,x2
    tick();
    chk("add_illegal", 32'(out_illegal), 32'd0);
    chk("add_imm", out_imm, 32'h2);

    drive(1'b1, 32'h0000007F, 32'h11C);  // unknown opcode
    tick();
    chk("ill_illegal", 32'(out_illegal), 32'd1);
    chk("ill_imm", out_imm, 32'h0);
    chk("ill_immsrc", 32'(out_immsrc), 32'd0);

    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_imm_zero", out_imm, 32'h0);

    // Backpressure: A and B fill the buffer, C is held off
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    tick();
    drive(1'b1, 32'h00200093, 32'h204);
    tick();
    drive(1'b1, 32'h00300093, 32'h208);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_A", out_pc, 32'h200);
    tick();
    chk("hold_head_A", out_pc, 32'h200);
    chk("hold_imm_A", out_imm, 32'h1);
    chk("hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("order_B", out_pc, 32'h204);
    chk("order_B_imm", out_imm, 32'h2);
    chk("order_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("order_C", out_pc, 32'h208);
    chk("order_C_imm", out_imm, 32'h3);
    tick();
    chk("order_empty", 32'(out_valid), 32'd0);

    // Flush while full with a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 32'h300);
    tick();
    drive(1'b1, 32'h00500093, 32'h304);
    tick();
    drive(1'b1, 32'h00600093, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_deliver", 32'(out_valid), 32'd0);

    // Reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'h00700093, 32'h400);
    tick();
    drive(1'b1, 32'h00800093, 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("prereset_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("afterrst_valid", 32'(out_valid), 32'd0);
    chk("afterrst_in_ready", 32'(in_ready), 32'd1);

    drive(1'b1, 32'h00900093, 32'h500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("afterrst_push_pc", out_pc, 32'h500);
    chk("afterrst_push_imm", out_imm, 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_imm_stage.md
DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  fetch side presents an instruction.
REQ-005 in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 in_instr  input  32  raw instruction word.
REQ-007 in_pc  input  32  instruction address.
REQ-008 flush  input  1  discard all buffered and incoming instructions.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer accepts; pop occurs when out_valid && out_ready at a rising edge.
REQ-011 out_instr, out_pc  output  32 each  head entry instruction and address.
REQ-012 out_immsrc  output  3  immediate format selector: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt.
REQ-013 out_imm  output  32  expanded immediate for head entry.
REQ-014 out_illegal  output  1  head entry opcode not recognised.

Function
REQ-015 Decode from in_instr[6:0]: 0000011/0010011/1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 0110111/0010111 -> 011; 1101111 -> 100; 0110011/1110011 -> 000, legal.
REQ-016 Any other opcode SHALL give immsrc 000, imm 0x00000000, illegal 1.
REQ-017 Immediate SHALL be computed combinationally at the input from the decoded selector: I {20{i[31]},i[31:20]}; S {20{i[31]},i[31:25],i[11:7]}; B {20{i[31]},i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {12{i[31]},i[19:12],i[20],i[30:21],0}; shamt {27'b0,i[24:20]}.
REQ-018 Decoded fields SHALL be stored with instr/pc in a 2-entry FIFO (skid buffer); outputs SHALL be driven from the head entry only.
REQ-019 Latency: an instruction accepted at edge N SHALL appear with out_valid=1 after edge N (same cycle as N+1 setup), one cycle.
REQ-020 in_ready SHALL be 1 when occupancy < 2, 0 when occupancy = 2; it SHALL NOT depend combinationally on out_ready.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; with out_ready held high, throughput SHALL be one instruction per cycle.
REQ-022 While out_valid=1 and out_ready=0, all out_* signals SHALL remain stable.
REQ-023 Order SHALL be preserved (FIFO); pointers SHALL wrap modulo 2.
REQ-024 flush=1 SHALL clear occupancy to 0 at that edge, dropping any concurrent push and pop; out_valid SHALL be 0 after that edge.
REQ-025 out_* data when out_valid=0 SHALL be 0.

Reset
REQ-026 rst=1 SHALL clear occupancy and pointers; out_valid=0, in_ready=0 while rst=1, and in_ready=1 in the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over flush, push and pop; reset mid-operation discards all entries.

Configuration
REQ-028 Macro SHAMT_IMM_EN defined: opcode 0010011 with funct3 001 or 101 SHALL decode to immsrc 101, imm = zero-extended i[24:20].
REQ-029 SHAMT_IMM_EN undefined: those instructions SHALL decode as I-type (immsrc 000); selector 101 SHALL never be produced.

Verification
REQ-030 in_instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, immsrc 000, imm 0xFFFFFFFF, illegal 0.
REQ-031 in_instr 0xFE000EE3 (beq x0,x0,-4) -> immsrc 010, imm 0xFFFFFFFC; 0x000000EF (jal) -> immsrc 100.
REQ-032 out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0 on third, out holds A; release out_ready -> A,B,C emerge in order, one per cycle.
REQ-033 Occupancy 2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming instruction not delivered.
REQ-034 in_instr 0x40315093 (srai x1,x2,3) -> with SHAMT_IMM_EN: immsrc 101, imm 0x00000003; without: immsrc 000, imm 0x00000403.
REQ-035 in_instr 0x0000007F -> illegal 1, imm 0; rst asserted with 2 entries -> out_valid 0 next cycle, no entry survives.
